shift_add_multiplier: RTL and testbench

Multi-cycle unsigned N x N -> 2N multiplier built around the team's N-bit ripple-carry adder. It is the sequential stage that consumes the adder's sum and carry-out every cycle. One partial product is accumulated per clock using the shift-and-add method, with a start/busy/done handshake toward the datapath controller. It is used by the lab ALU for MUL ops where a single-cycle array multiplier is too large.

---
 rtl/mul_pkg.sv | 15 +
 rtl/NbitAdder.sv | 20 ++
 rtl/shift_add_multiplier.sv | 84 ++++++++
 tb/tb_shift_add_multiplier.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: state encoding and counter-width helper for the shift-add multiplier.
package mul_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/NbitAdder.sv
// NbitAdder: N-bit ripple-carry adder built from a chain of full adders.
module NbitAdder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carryin,
    output logic [N-1:0] sum,
    output logic         carryout
);
    logic [N:0] c;

    assign c[0]     = carryin;
    assign carryout = c[N];

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: unsigned N x N -> 2N multiplier, one partial product per clock
// through a shared ripple-carry adder, with start/busy/done handshake.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = clog2(N) + 1;

    state_t         state_q, state_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   mq_q, mq_d;
    logic [CW-1:0]  count_q, count_d;
    logic [2*N-1:0] product_q, product_d;
    logic [N-1:0]   sum;
    logic           cout;

    NbitAdder #(.N(N)) u_add (
        .a        (acc_q),
        .b        (mq_q[0] ? mcand_q : '0),
        .carryin  (1'b0),
        .sum      (sum),
        .carryout (cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        count_d   = count_q;
        product_d = product_q;
        if (state_q == ST_RUN) begin
            // shift {cout, sum, mq} right one place; carry-out lands in acc msb
            acc_d   = {cout, sum[N-1:1]};
            mq_d    = {sum[0], mq_q[N-1:1]};
            count_d = count_q + 1'b1;
            if (count_q == CW'(N - 1)) begin
                product_d = {cout, sum, mq_q[N-1:1]};
                state_d   = ST_DONE;
            end
        end else if (start) begin
            mcand_d = A;
            mq_d    = B;
            acc_d   = '0;
            count_d = '0;
            state_d = ST_RUN;
        end else begin
            state_d = ST_IDLE;
        end
    end

    assign busy    = state_q == ST_RUN;
    assign done    = state_q == ST_DONE;
    assign product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed and random checks of the shift-add multiplier
// against plain-arithmetic products and the N-cycle handshake timing.
module tb_shift_add_multiplier;
    logic        clk = 0;
    logic        reset = 1;
    logic        start = 0;
    logic [31:0] a = 0, b = 0;
    logic        busy, done;
    logic [63:0] product;
    logic        start8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic        busy8, done8;
    logic [15:0] product8;
    int          vecs = 0;
    int          errs = 0;

    shift_add_multiplier #(.N(32)) dut (
        .clk(clk), .reset(reset), .start(start), .A(a), .B(b),
        .busy(busy), .done(done), .product(product)
    );

    shift_add_multiplier #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .product(product8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one 32-bit multiply, optionally re-pulsing start mid-run, and
    // returns in the done cycle so the caller can chain another start.
    task automatic mul32(input logic [31:0] x, input logic [31:0] y, input int pulse_at);
        int          cyc;
        bit          ok;
        logic [63:0] held;
        held  = product;
        start = 1; a = x; b = y;
        step();
        start = 0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        cyc = 0;
        ok  = 1;
        while (!done && cyc < 40) begin
            start = (cyc == pulse_at);
            if (cyc == pulse_at) begin a = 32'd2; b = 32'd2; end
            step();
            cyc++;
            if (!done) ok &= busy && product === held;
        end
        start = 0;
        chk("latency", 64'(cyc), 64'd32);
        chk("run_busy_product_stable", 64'(ok), 64'd1);
        chk("done_busy_low", 64'(busy), 64'd0);
        chk("product", product, 64'(x) * 64'(y));
    endtask

    task automatic idle_after();
        step();
        chk("done_single_pulse", 64'({done, busy}), 64'd0);
    endtask

    task automatic mul8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] held);
        int cyc;
        bit ok;
        start8 = 1; a8 = x; b8 = y;
        step();
        start8 = 0;
        cyc = 0;
        ok  = 1;
        while (!done8 && cyc < 20) begin
            step();
            cyc++;
            if (!done8) ok &= busy8 && product8 === held;
        end
        chk("n8_latency", 64'(cyc), 64'd8);
        chk("n8_run_stable", 64'(ok), 64'd1);
        chk("n8_product", 64'(product8), 64'(16'(x) * 16'(y)));
        step();
        chk("n8_done_pulse", 64'(done8), 64'd0);
    endtask

    initial begin
        logic [31:0] rx, ry;
        bit          no_done;
        step();
        step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        chk("reset_product8", 64'(product8), 64'd0);
        reset = 0;
        step();
        chk("idle_no_start", 64'({busy, done}), 64'd0);

        mul32(32'd3, 32'd5, -1);
        idle_after();
        chk("product_held_idle", product, 64'h0000_0000_0000_000F);
        mul32(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        idle_after();
        mul32(32'd0, 32'hDEAD_BEEF, -1);
        idle_after();
        for (int i = 0; i < 6; i++) begin
            rx = $urandom;
            ry = (i == 0) ? 32'h8000_0001 : $urandom;
            mul32(rx, ry, -1);
            idle_after();
        end

        // start mid-run is ignored; start in the done cycle chains directly
        mul32(32'd7, 32'd9, 10);
        chk("ignored_start_product", product, 64'd63);
        mul32(32'd2, 32'd2, -1);
        idle_after();

        // reset aborts a run: no partial result, no done pulse
        start = 1; a = 32'd100; b = 32'd100;
        step();
        start = 0;
        repeat (15) step();
        reset = 1;
        step();
        reset = 0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_product", product, 64'd0);
        no_done = 1;
        repeat (40) begin
            step();
            no_done &= !done && !busy;
        end
        chk("abort_no_done", 64'(no_done), 64'd1);

        mul8(8'hFF, 8'h02, 16'h0000);
        chk("n8_ff_x_02", 64'(product8), 64'h01FE);
        rx = $urandom;
        mul8(rx[7:0], rx[15:8], 16'h01FE);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
